// File: rtl/bulk_app_width_adapter.sv
// Width adapter between N-byte application words and the byte-wide bulk endpoint FIFOs.
// TX serialises kept lanes in ascending order; RX packs bytes and flushes partial words on idle timeout.
module bulk_app_width_adapter #(
  parameter int APP_BYTES         = 4,
  parameter int RX_TIMEOUT_CYCLES = 1024
) (
  input  logic                   app_clk_i,
  input  logic                   rstn,
  input  logic [8*APP_BYTES-1:0] app_tx_data_i,
  input  logic [APP_BYTES-1:0]   app_tx_keep_i,
  input  logic                   app_tx_valid_i,
  output logic                   app_tx_ready_o,
  output logic [7:0]             byte_in_data_o,
  output logic                   byte_in_valid_o,
  input  logic                   byte_in_ready_i,
  input  logic [7:0]             byte_out_data_i,
  input  logic                   byte_out_valid_i,
  output logic                   byte_out_ready_o,
  output logic [8*APP_BYTES-1:0] app_rx_data_o,
  output logic [APP_BYTES-1:0]   app_rx_keep_o,
  output logic                   app_rx_valid_o,
  input  logic                   app_rx_ready_i
);

  localparam int DW = 8 * APP_BYTES;
  localparam int FW = $clog2(APP_BYTES + 1);
  localparam int CW = (RX_TIMEOUT_CYCLES > 0) ? $clog2(RX_TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  tx_state_e            tx_state;
  tx_state_e            tx_state_next;
  logic [DW-1:0]        tx_data;
  logic [APP_BYTES-1:0] tx_rem;
  logic [APP_BYTES-1:0] tx_cur;
  logic                 tx_last;
  logic                 tx_hs;
  logic                 tx_accept;
  logic                 tx_load;
  logic [7:0]           tx_lane_byte;

  // tx_rem holds the lanes still to send; its lowest set bit is the lane on the wire.
  assign tx_cur    = tx_rem & (~tx_rem + APP_BYTES'(1));
  assign tx_last   = (tx_rem & ~tx_cur) == '0;
  assign tx_hs     = (tx_state == TX_SEND) & byte_in_ready_i;
  assign tx_accept = app_tx_valid_i & app_tx_ready_o;
  assign tx_load   = tx_accept & (|app_tx_keep_i);

  always_ff @(posedge app_clk_i or negedge rstn) begin
    if (!rstn) begin
      tx_state <= TX_IDLE;
    end else begin
      tx_state <= tx_state_next;
    end
  end

  always_comb begin
    tx_state_next = tx_state;
    case (tx_state)
      TX_IDLE: if (tx_load) tx_state_next = TX_SEND;
      TX_SEND: if (tx_hs && tx_last && !tx_load) tx_state_next = TX_IDLE;
      default: tx_state_next = TX_IDLE;
    endcase
  end

  always_comb begin
    byte_in_valid_o = 1'b0;
    byte_in_data_o  = 8'h00;
    app_tx_ready_o  = 1'b0;
    case (tx_state)
      TX_IDLE: app_tx_ready_o = 1'b1;
      TX_SEND: begin
        byte_in_valid_o = 1'b1;
        byte_in_data_o  = tx_lane_byte;
        app_tx_ready_o  = byte_in_ready_i & tx_last;
      end
      default: ;
    endcase
  end

  always_comb begin
    tx_lane_byte = 8'h00;
    for (int k = 0; k < APP_BYTES; k++) begin
      if (tx_cur[k]) tx_lane_byte = tx_data[8*k +: 8];
    end
  end

  always_ff @(posedge app_clk_i or negedge rstn) begin
    if (!rstn) begin
      tx_data <= '0;
      tx_rem  <= '0;
    end else if (tx_load) begin
      tx_data <= app_tx_data_i;
      tx_rem  <= app_tx_keep_i;
    end else if (tx_hs) begin
      tx_rem <= tx_rem & ~tx_cur;
    end
  end

  logic [FW-1:0]        rx_fill;
  logic                 rx_accept;
  logic                 rx_timeout_fire;
  logic [APP_BYTES-1:0] rx_partial_keep;

  // A pending word blocks the byte stream; ready returns the cycle after the word is taken.
  assign byte_out_ready_o = ~app_rx_valid_o;
  assign rx_accept        = byte_out_valid_i & byte_out_ready_o;

  always_comb begin
    rx_partial_keep = '0;
    for (int k = 0; k < APP_BYTES; k++) begin
      rx_partial_keep[k] = FW'(k) < rx_fill;
    end
  end

  generate
    if (RX_TIMEOUT_CYCLES > 0) begin : g_timeout
      logic [CW-1:0] rx_idle_cnt;

      always_ff @(posedge app_clk_i or negedge rstn) begin
        if (!rstn) begin
          rx_idle_cnt <= '0;
        end else if (rx_accept || rx_timeout_fire) begin
          rx_idle_cnt <= '0;
        end else if (rx_fill != '0 && !app_rx_valid_o) begin
          rx_idle_cnt <= rx_idle_cnt + CW'(1);
        end
      end

      // Fires on the edge where the idle count would reach the limit; an arriving byte wins.
      assign rx_timeout_fire = !rx_accept && !app_rx_valid_o && (rx_fill != '0) &&
                               (rx_idle_cnt == CW'(RX_TIMEOUT_CYCLES - 1));
    end else begin : g_no_timeout
      assign rx_timeout_fire = 1'b0;
    end
  endgenerate

  always_ff @(posedge app_clk_i or negedge rstn) begin
    if (!rstn) begin
      rx_fill        <= '0;
      app_rx_data_o  <= '0;
      app_rx_keep_o  <= '0;
      app_rx_valid_o <= 1'b0;
    end else begin
      if (app_rx_valid_o && app_rx_ready_i) app_rx_valid_o <= 1'b0;
      if (rx_accept) begin
        for (int k = 0; k < APP_BYTES; k++) begin
          if (rx_fill == '0) begin
            app_rx_data_o[8*k +: 8] <= (k == 0) ? byte_out_data_i : 8'h00;
          end else if (rx_fill == FW'(k)) begin
            app_rx_data_o[8*k +: 8] <= byte_out_data_i;
          end
        end
        if (rx_fill == FW'(APP_BYTES - 1)) begin
          app_rx_valid_o <= 1'b1;
          app_rx_keep_o  <= '1;
          rx_fill        <= '0;
        end else begin
          rx_fill <= rx_fill + FW'(1);
        end
      end else if (rx_timeout_fire) begin
        app_rx_valid_o <= 1'b1;
        app_rx_keep_o  <= rx_partial_keep;
        rx_fill        <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bulk_app_width_adapter.sv
// Scoreboard bench for bulk_app_width_adapter: expected bytes/words are queued at stimulus time
// and compared by negedge monitors as the DUT hands them off.
module tb_bulk_app_width_adapter;

  localparam int APP_BYTES = 4;
  localparam int RX_TO     = 16;

  logic        app_clk_i = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] app_tx_data_i = '0;
  logic [3:0]  app_tx_keep_i = '0;
  logic        app_tx_valid_i = 1'b0;
  logic        app_tx_ready_o;
  logic [7:0]  byte_in_data_o;
  logic        byte_in_valid_o;
  logic        byte_in_ready_i = 1'b1;
  logic [7:0]  byte_out_data_i = '0;
  logic        byte_out_valid_i = 1'b0;
  logic        byte_out_ready_o;
  logic [31:0] app_rx_data_o;
  logic [3:0]  app_rx_keep_o;
  logic        app_rx_valid_o;
  logic        app_rx_ready_i = 1'b1;

  bulk_app_width_adapter #(.APP_BYTES(APP_BYTES), .RX_TIMEOUT_CYCLES(RX_TO)) dut (
    .app_clk_i(app_clk_i), .rstn(rstn),
    .app_tx_data_i(app_tx_data_i), .app_tx_keep_i(app_tx_keep_i),
    .app_tx_valid_i(app_tx_valid_i), .app_tx_ready_o(app_tx_ready_o),
    .byte_in_data_o(byte_in_data_o), .byte_in_valid_o(byte_in_valid_o),
    .byte_in_ready_i(byte_in_ready_i),
    .byte_out_data_i(byte_out_data_i), .byte_out_valid_i(byte_out_valid_i),
    .byte_out_ready_o(byte_out_ready_o),
    .app_rx_data_o(app_rx_data_o), .app_rx_keep_o(app_rx_keep_o),
    .app_rx_valid_o(app_rx_valid_o), .app_rx_ready_i(app_rx_ready_i)
  );

  always #5 app_clk_i = ~app_clk_i;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  tx_exp[$];
  logic [35:0] rx_exp[$];
  logic        rnd_ready = 1'b0;
  logic        tx_prev_stall = 1'b0;
  logic [7:0]  tx_prev_data = '0;
  logic [7:0]  tx_want;
  logic [35:0] rx_want;

  // TX monitor: stalled bytes must hold, handshaken bytes must match the scoreboard.
  always @(negedge app_clk_i) begin
    if (tx_prev_stall) begin
      checks++;
      if (byte_in_valid_o !== 1'b1 || byte_in_data_o !== tx_prev_data) begin
        failures++;
        $display("[TB] FAIL tx_hold: valid=%b data=%h, required valid=1 data=%h", byte_in_valid_o, byte_in_data_o, tx_prev_data);
      end
    end
    tx_prev_stall = rstn && byte_in_valid_o && !byte_in_ready_i;
    tx_prev_data  = byte_in_data_o;
    if (byte_in_valid_o && byte_in_ready_i) begin
      checks++;
      if (tx_exp.size() == 0) begin
        failures++;
        $display("[TB] FAIL tx_unexpected: got byte %h, required no byte", byte_in_data_o);
      end else begin
        tx_want = tx_exp.pop_front();
        if (byte_in_data_o !== tx_want) begin
          failures++;
          $display("[TB] FAIL tx_byte: got %h, required %h", byte_in_data_o, tx_want);
        end
      end
    end
  end

  // RX monitor: every consumed word is compared as {keep, data}.
  always @(negedge app_clk_i) begin
    if (app_rx_valid_o && app_rx_ready_i) begin
      checks++;
      if (rx_exp.size() == 0) begin
        failures++;
        $display("[TB] FAIL rx_unexpected: got keep=%h data=%h, required no word", app_rx_keep_o, app_rx_data_o);
      end else begin
        rx_want = rx_exp.pop_front();
        if ({app_rx_keep_o, app_rx_data_o} !== rx_want) begin
          failures++;
          $display("[TB] FAIL rx_word: got keep=%h data=%h, required keep=%h data=%h", app_rx_keep_o, app_rx_data_o, rx_want[35:32], rx_want[31:0]);
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic [3:0] k);
    int n;
    for (int i = 0; i < 4; i++) if (k[i]) tx_exp.push_back(d[8*i +: 8]);
    app_tx_data_i = d; app_tx_keep_i = k; app_tx_valid_i = 1'b1;
    n = 0;
    @(negedge app_clk_i);
    while (!app_tx_ready_o && n < 50) begin
      @(posedge app_clk_i); #1;
      if (rnd_ready) byte_in_ready_i = 1'($urandom_range(0, 1));
      @(negedge app_clk_i);
      n++;
    end
    checks++;
    if (!app_tx_ready_o) begin failures++; $display("[TB] FAIL tx_accept_timeout: ready=%b, required 1", app_tx_ready_o); end
    @(posedge app_clk_i); #1;
    app_tx_valid_i = 1'b0;
    if (rnd_ready) byte_in_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic send_byte(input logic [7:0] b, output int stalls);
    stalls = 0;
    byte_out_data_i = b; byte_out_valid_i = 1'b1;
    @(negedge app_clk_i);
    while (!byte_out_ready_o && stalls < 50) begin
      @(posedge app_clk_i); #1;
      @(negedge app_clk_i);
      stalls++;
    end
    checks++;
    if (!byte_out_ready_o) begin failures++; $display("[TB] FAIL rx_byte_timeout: ready=%b, required 1", byte_out_ready_o); end
    @(posedge app_clk_i); #1;
    byte_out_valid_i = 1'b0;
  endtask

  task automatic wait_tx_drain();
    int n = 0;
    while ((tx_exp.size() != 0 || byte_in_valid_o) && n < 200) begin
      @(posedge app_clk_i); #1;
      if (rnd_ready) byte_in_ready_i = 1'($urandom_range(0, 1));
      n++;
    end
    checks++;
    if (tx_exp.size() != 0 || byte_in_valid_o) begin
      failures++; $display("[TB] FAIL tx_drain: pending=%0d valid=%b, required 0 and 0", tx_exp.size(), byte_in_valid_o);
    end
  endtask

  task automatic wait_rx_drain();
    int n = 0;
    while (rx_exp.size() != 0 && n < 200) begin
      @(posedge app_clk_i); #1;
      n++;
    end
    checks++;
    if (rx_exp.size() != 0) begin failures++; $display("[TB] FAIL rx_drain: pending=%0d, required 0", rx_exp.size()); end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (byte_in_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_in_valid: got %b, required 0", byte_in_valid_o); end
    checks++; if (byte_in_data_o !== 8'h00) begin failures++; $display("[TB] FAIL rst_in_data: got %h, required 00", byte_in_data_o); end
    checks++; if (app_rx_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_rx_valid: got %b, required 0", app_rx_valid_o); end
    checks++; if (app_rx_data_o !== 32'h0) begin failures++; $display("[TB] FAIL rst_rx_data: got %h, required 0", app_rx_data_o); end
    checks++; if (app_rx_keep_o !== 4'h0) begin failures++; $display("[TB] FAIL rst_rx_keep: got %h, required 0", app_rx_keep_o); end
    #10 rstn = 1'b1;
    @(posedge app_clk_i); #1;
    checks++; if (app_tx_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL rst_tx_ready: got %b, required 1", app_tx_ready_o); end
    checks++; if (byte_out_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL rst_out_ready: got %b, required 1", byte_out_ready_o); end
  endtask

  task automatic test_tx_full();
    byte_in_ready_i = 1'b1;
    send_word(32'h44332211, 4'hF);
    for (int i = 0; i < 4; i++) begin
      @(negedge app_clk_i);
      checks++; if (byte_in_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL tx_full_valid[%0d]: got %b, required 1", i, byte_in_valid_o); end
      checks++; if (app_tx_ready_o !== (i == 3)) begin failures++; $display("[TB] FAIL tx_full_ready[%0d]: got %b, required %b", i, app_tx_ready_o, (i == 3)); end
      @(posedge app_clk_i); #1;
    end
    @(negedge app_clk_i);
    checks++; if (byte_in_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL tx_full_idle: got %b, required 0", byte_in_valid_o); end
    @(posedge app_clk_i); #1;
    wait_tx_drain();
  endtask

  task automatic test_tx_sparse();
    send_word(32'hDDCCBBAA, 4'b1010);
    send_word(32'h00000000, 4'b0000);
    @(negedge app_clk_i);
    checks++; if (byte_in_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL tx_zero_keep_valid: got %b, required 0", byte_in_valid_o); end
    checks++; if (tx_exp.size() != 0) begin failures++; $display("[TB] FAIL tx_sparse_pending: got %0d, required 0", tx_exp.size()); end
    @(posedge app_clk_i); #1;
  endtask

  task automatic test_back_to_back();
    send_word(32'h44332211, 4'hF);
    send_word(32'h88776655, 4'hF);
    for (int i = 0; i < 4; i++) begin
      @(negedge app_clk_i);
      checks++; if (byte_in_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL b2b_valid[%0d]: got %b, required 1", i, byte_in_valid_o); end
      @(posedge app_clk_i); #1;
    end
    @(negedge app_clk_i);
    checks++; if (byte_in_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle: got %b, required 0", byte_in_valid_o); end
    @(posedge app_clk_i); #1;
    wait_tx_drain();
  endtask

  task automatic test_tx_backpressure();
    rnd_ready = 1'b1;
    send_word(32'hA1B2C3D4, 4'hF);
    send_word(32'h0F0E0D0C, 4'b0101);
    send_word(32'h11223344, 4'b1000);
    wait_tx_drain();
    rnd_ready = 1'b0;
    byte_in_ready_i = 1'b1;
  endtask

  task automatic test_rx_stream();
    int st;
    app_rx_ready_i = 1'b1;
    rx_exp.push_back({4'hF, 32'h04030201});
    rx_exp.push_back({4'hF, 32'h08070605});
    for (int b = 1; b <= 8; b++) begin
      send_byte(8'(b), st);
      checks++; if (st != ((b == 5) ? 1 : 0)) begin failures++; $display("[TB] FAIL rx_stall[%0d]: got %0d, required %0d", b, st, (b == 5) ? 1 : 0); end
    end
    @(negedge app_clk_i);
    checks++; if (app_rx_valid_o !== 1'b1 || byte_out_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL rx_word2_flags: valid=%b ready=%b, required 1 0", app_rx_valid_o, byte_out_ready_o); end
    @(posedge app_clk_i); #1;
    @(negedge app_clk_i);
    checks++; if (byte_out_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL rx_ready_return: got %b, required 1", byte_out_ready_o); end
    @(posedge app_clk_i); #1;
    wait_rx_drain();
  endtask

  task automatic test_rx_timeout();
    int st;
    int idle = 0;
    rx_exp.push_back({4'b0011, 32'h0000BBAA});
    send_byte(8'hAA, st);
    send_byte(8'hBB, st);
    @(negedge app_clk_i);
    while (!app_rx_valid_o && idle < 40) begin
      idle++;
      @(negedge app_clk_i);
    end
    checks++; if (idle != RX_TO) begin failures++; $display("[TB] FAIL rx_timeout_cycles: got %0d, required %0d", idle, RX_TO); end
    @(posedge app_clk_i); #1;
    wait_rx_drain();
  endtask

  task automatic test_rx_timeout_priority();
    int st;
    rx_exp.push_back({4'hF, 32'hEEDDCCAA});
    send_byte(8'hAA, st);
    repeat (RX_TO - 1) @(posedge app_clk_i);
    #1;
    send_byte(8'hCC, st);
    send_byte(8'hDD, st);
    send_byte(8'hEE, st);
    wait_rx_drain();
  endtask

  task automatic test_rx_backpressure();
    int st;
    int n = 0;
    app_rx_ready_i = 1'b0;
    rx_exp.push_back({4'hF, 32'h14131211});
    rx_exp.push_back({4'hF, 32'h18171615});
    for (int b = 8'h11; b <= 8'h14; b++) send_byte(8'(b), st);
    byte_out_data_i = 8'h15; byte_out_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge app_clk_i);
      checks++; if (byte_out_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL rx_hold_ready[%0d]: got %b, required 0", i, byte_out_ready_o); end
      checks++; if ({app_rx_valid_o, app_rx_keep_o, app_rx_data_o} !== {1'b1, 4'hF, 32'h14131211}) begin
        failures++; $display("[TB] FAIL rx_hold_word[%0d]: valid=%b keep=%h data=%h, required 1 F 14131211", i, app_rx_valid_o, app_rx_keep_o, app_rx_data_o);
      end
      @(posedge app_clk_i); #1;
    end
    app_rx_ready_i = 1'b1;
    @(negedge app_clk_i);
    while (!byte_out_ready_o && n < 10) begin
      @(posedge app_clk_i); #1;
      @(negedge app_clk_i);
      n++;
    end
    checks++; if (byte_out_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL rx_resume: got %b, required 1", byte_out_ready_o); end
    @(posedge app_clk_i); #1;
    byte_out_valid_i = 1'b0;
    for (int b = 8'h16; b <= 8'h18; b++) send_byte(8'(b), st);
    wait_rx_drain();
  endtask

  task automatic test_mid_reset();
    int st;
    byte_in_ready_i = 1'b1;
    send_byte(8'h77, st);
    send_byte(8'h88, st);
    send_word(32'h44332211, 4'hF);
    void'(tx_exp.pop_back());
    void'(tx_exp.pop_back());
    @(posedge app_clk_i);
    @(posedge app_clk_i);
    #2 rstn = 1'b0;
    #1;
    checks++; if (byte_in_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_valid: got %b, required 0", byte_in_valid_o); end
    checks++; if (tx_exp.size() != 0) begin failures++; $display("[TB] FAIL mid_rst_sent: pending=%0d, required 0", tx_exp.size()); end
    repeat (2) @(posedge app_clk_i);
    #2 rstn = 1'b1;
    @(posedge app_clk_i); #1;
    checks++; if (app_tx_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL mid_rst_tx_ready: got %b, required 1", app_tx_ready_o); end
    checks++; if (byte_out_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL mid_rst_out_ready: got %b, required 1", byte_out_ready_o); end
    repeat (2 * RX_TO) @(posedge app_clk_i);
    #1;
    checks++; if (byte_in_valid_o !== 1'b0 || app_rx_valid_o !== 1'b0) begin
      failures++; $display("[TB] FAIL mid_rst_stale: in_valid=%b rx_valid=%b, required 0 0", byte_in_valid_o, app_rx_valid_o);
    end
    rx_exp.push_back({4'hF, 32'h04030201});
    for (int b = 1; b <= 4; b++) send_byte(8'(b), st);
    wait_rx_drain();
  endtask

  initial begin
    test_reset();
    test_tx_full();
    test_tx_sparse();
    test_back_to_back();
    test_tx_backpressure();
    test_rx_stream();
    test_rx_timeout();
    test_rx_timeout_priority();
    test_rx_backpressure();
    test_mid_reset();
    repeat (4) @(posedge app_clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/bulk_app_width_adapter.md
Name: bulk_app_width_adapter

Overview:
- Application-side width adapter that sits between user logic and the byte-wide app FIFO interface of the bulk endpoint pair.
- Serialises N-byte application words into the IN byte stream, and packs the OUT byte stream into N-byte words.
- On the OUT side, an idle timeout flushes a partially filled word with a byte-keep mask, so short USB packets reach the application without waiting for more data.
- Runs entirely in the app_clk_i domain.

Parameters:
- APP_BYTES, 4, word width in bytes (1..8); app data width is 8*APP_BYTES.
- RX_TIMEOUT_CYCLES, 1024, app_clk_i cycles of OUT byte inactivity before a partial word is flushed; 0 disables flushing (only full words are emitted).

Ports:
- app_clk_i  in  1  application clock; all logic on its rising edge.
- rstn  in  1  asynchronous, active-low reset.
- app_tx_data_i  in  8*APP_BYTES  word to transmit; byte lane k = bits [8k+7:8k].
- app_tx_keep_i  in  APP_BYTES  lane-valid mask for app_tx_data_i.
- app_tx_valid_i  in  1  tx word valid.
- app_tx_ready_o  out  1  tx word accepted when ready & valid.
- byte_in_data_o  out  8  byte to bulk endpoint app_in_data.
- byte_in_valid_o  out  1  byte valid.
- byte_in_ready_i  in  1  endpoint accepts byte when ready & valid.
- byte_out_data_i  in  8  byte from bulk endpoint app_out_data.
- byte_out_valid_i  in  1  byte valid.
- byte_out_ready_o  out  1  adapter accepts byte when ready & valid.
- app_rx_data_o  out  8*APP_BYTES  packed received word; unfilled lanes are 0.
- app_rx_keep_o  out  APP_BYTES  lane-valid mask; always contiguous from lane 0.
- app_rx_valid_o  out  1  rx word valid; data/keep stable until accepted.
- app_rx_ready_i  in  1  app consumes word when ready & valid.

Behaviour:
- Reset (rstn low, async): TX FSM in IDLE; byte_in_valid_o=0; byte_in_data_o=0; app_rx_valid_o=0; app_rx_data_o=0; app_rx_keep_o=0; RX fill count=0; timeout counter=0.
- After reset release: app_tx_ready_o=1 and byte_out_ready_o=1.

TX path (FSM IDLE/SEND):
- app_tx_ready_o = (state==IDLE) | (state==SEND & current byte handshaken & it is the last kept lane). This gives back-to-back words with no bubble.
- Accepting a word with keep!=0: latch data and keep, then go to SEND. byte_in_valid_o rises on the next cycle with the lowest kept lane.
- Accepting a word with keep==0: the word is consumed and dropped; state stays IDLE; no byte is sent.
- In SEND: bytes with keep=1 are presented in ascending lane order; cleared lanes are skipped with zero cycle cost.
  - A byte advances only on byte_in_ready_i & byte_in_valid_o.
  - byte_in_valid_o and byte_in_data_o are held while ready is low.
- After the last kept lane is handshaken: if a new word is accepted in the same cycle, stay in SEND with the new word; otherwise go to IDLE and drop byte_in_valid_o.
- Latency: word accept to first byte valid is 1 cycle. Throughput is 1 byte/cycle when byte_in_ready_i is held high.

RX path:
- byte_out_ready_o = ~app_rx_valid_o. The single output buffer stalls the byte stream while a word is pending.
- Each accepted byte is written into lane[fill]; fill increments.
  - When fill reaches APP_BYTES: on the next cycle, app_rx_valid_o=1, keep=all ones, fill=0.
- Timeout counter:
  - Clears on every accepted byte.
  - Increments only while 0<fill<APP_BYTES and app_rx_valid_o=0.
  - On reaching RX_TIMEOUT_CYCLES: emit the partial word with keep=(1<<fill)-1, then fill=0 and counter=0.
- app_rx_valid_o clears on app_rx_ready_i. byte_out_ready_o returns high in the following cycle (no combinational ready-to-ready path). app_rx_data_o lanes are cleared when a new word starts filling.
- If a byte arrives in the same cycle the timeout expires: the byte takes priority, is included in the word, and the counter is cleared.
- Counter width is clog2(RX_TIMEOUT_CYCLES+1). With RX_TIMEOUT_CYCLES=0 the counter is removed and partial words wait indefinitely.
- APP_BYTES=1: each byte is emitted as a word with keep=1 and 1-cycle latency; the timeout never fires.
- Mid-operation reset: any partially sent word and any partially packed word are discarded; no byte or word is emitted after rstn rises until new input arrives.

Test Plan:
- APP_BYTES=4; push 0x44332211 keep=4'hF with byte_in_ready_i=1 -> bytes 11,22,33,44 on consecutive cycles starting 1 cycle after accept; app_tx_ready_o high on the 4th byte cycle.
- Push 0xDDCCBBAA keep=4'b1010 then 0x00000000 keep=0 -> only bytes BB,DD sent; the zero-keep word is consumed with no byte output.
- Stream bytes 01..08 with app_rx_ready_i=1 -> words 0x04030201 and 0x08070605, keep=F; byte_out_ready_o low exactly one cycle after each word asserts.
- RX_TIMEOUT_CYCLES=16; send bytes AA,BB, then idle -> after 16 idle cycles app_rx_data_o=0x0000BBAA, keep=4'b0011.
- Hold app_rx_ready_i=0 with a full word pending -> byte_out_ready_o stays 0 and no byte is lost; releasing ready resumes packing in order.
- Assert rstn=0 during SEND after 2 of 4 bytes -> byte_in_valid_o=0 immediately; after release app_tx_ready_o=1 and no stale bytes appear.
